// File: rtl/aidc_lite_cfg_if.sv
// APB slave bus bundle for the AIDC lite job-configuration block.
interface aidc_lite_cfg_if #(
  parameter int ADDR_W = 12
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/aidc_lite_cfg.sv
// APB register block that builds a copy-engine job descriptor and tracks its run.
// Optional completion interrupt (INTR register at 0x18, irq_o) enabled by AIDC_LITE_CFG_IRQ_EN.
module aidc_lite_cfg #(
  parameter int ADDR_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  aidc_lite_cfg_if.slave apb,
  output logic [31:0]    src_addr_o,
  output logic [31:0]    dst_addr_o,
  output logic [31:0]    len_o,
  output logic           start_o,
  input  logic           done_i,
  output logic           busy_o
`ifdef AIDC_LITE_CFG_IRQ_EN
  ,
  output logic           irq_o
`endif
);

  localparam logic [ADDR_W-1:0] A_SRC    = ADDR_W'(32'h0000_0000);
  localparam logic [ADDR_W-1:0] A_DST    = ADDR_W'(32'h0000_0004);
  localparam logic [ADDR_W-1:0] A_LEN    = ADDR_W'(32'h0000_0008);
  localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(32'h0000_000C);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h0000_0010);
  localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(32'h0000_0014);
`ifdef AIDC_LITE_CFG_IRQ_EN
  localparam logic [ADDR_W-1:0] A_INTR   = ADDR_W'(32'h0000_0018);
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_r;
  state_e      state_nxt_s;
  logic        run_s;
  logic [31:0] src_r;
  logic [31:0] dst_r;
  logic [31:0] len_r;
  logic [31:0] cycles_r;
  logic [31:0] prdata_r;
  logic [31:0] rdata_s;
  logic        done_r;
  logic        start_r;
  logic        wr_acc_s;
  logic        rd_setup_s;
  logic        cfg_sel_s;
  logic        wr_ok_s;
  logic        start_req_s;
  logic        accept_s;
  logic        null_job_s;
  logic        done_ev_s;
`ifdef AIDC_LITE_CFG_IRQ_EN
  logic        intr_en_r;
  logic        intr_pend_r;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (done_i) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      ST_RUN:  run_s = 1'b1;
      ST_IDLE: run_s = 1'b0;
      default: run_s = 1'b0;
    endcase
  end

  // APB phase decode and job-launch qualification; a coinciding done_i still sees RUN here
  always_comb begin
    wr_acc_s    = apb.psel & apb.penable & apb.pwrite;
    rd_setup_s  = apb.psel & ~apb.penable & ~apb.pwrite;
    cfg_sel_s   = (apb.paddr == A_SRC) | (apb.paddr == A_DST) |
                  (apb.paddr == A_LEN) | (apb.paddr == A_CMD);
    wr_ok_s     = wr_acc_s & ~run_s;
    start_req_s = wr_ok_s & (apb.paddr == A_CMD) & apb.pwdata[0];
    accept_s    = start_req_s & (len_r != 32'h0000_0000);
    null_job_s  = start_req_s & (len_r == 32'h0000_0000);
    done_ev_s   = run_s & done_i;
  end

  // Descriptor registers, frozen while a job is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_r <= 32'h0000_0000;
      dst_r <= 32'h0000_0000;
      len_r <= 32'h0000_0000;
    end else begin
      if (wr_ok_s && (apb.paddr == A_SRC)) src_r <= apb.pwdata;
      if (wr_ok_s && (apb.paddr == A_DST)) dst_r <= apb.pwdata;
      if (wr_ok_s && (apb.paddr == A_LEN)) len_r <= {apb.pwdata[31:2], 2'b00};
    end
  end

  // Launch pulse, done flag and saturating run-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r  <= 1'b0;
      done_r   <= 1'b0;
      cycles_r <= 32'h0000_0000;
    end else begin
      start_r <= accept_s;
      if (accept_s)                     done_r <= 1'b0;
      else if (null_job_s || done_ev_s) done_r <= 1'b1;
      if (accept_s)                                   cycles_r <= 32'h0000_0000;
      else if (run_s && (cycles_r != 32'hFFFF_FFFF))  cycles_r <= cycles_r + 32'd1;
    end
  end

`ifdef AIDC_LITE_CFG_IRQ_EN
  // Interrupt enable and pending; a completion on the same edge beats the W1C clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_en_r   <= 1'b0;
      intr_pend_r <= 1'b0;
    end else begin
      if (wr_acc_s && (apb.paddr == A_INTR)) intr_en_r <= apb.pwdata[0];
      if (null_job_s || done_ev_s)                                    intr_pend_r <= 1'b1;
      else if (wr_acc_s && (apb.paddr == A_INTR) && apb.pwdata[1])    intr_pend_r <= 1'b0;
    end
  end

  assign irq_o = intr_en_r & intr_pend_r;
`endif

  // Read-data mux; CMD and unmapped addresses read as zero
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (apb.paddr)
      A_SRC:    rdata_s = src_r;
      A_DST:    rdata_s = dst_r;
      A_LEN:    rdata_s = len_r;
      A_STATUS: rdata_s = {30'd0, run_s, done_r};
      A_CYCLES: rdata_s = cycles_r;
`ifdef AIDC_LITE_CFG_IRQ_EN
      A_INTR:   rdata_s = {30'd0, intr_pend_r, intr_en_r};
`endif
      default:  rdata_s = 32'h0000_0000;
    endcase
  end

  // Read data captured in the setup phase so it is stable for the whole access phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata_r <= 32'h0000_0000;
    end else if (rd_setup_s) begin
      prdata_r <= rdata_s;
    end
  end

  assign apb.prdata  = prdata_r;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = wr_acc_s & cfg_sel_s & run_s;
  assign src_addr_o  = src_r;
  assign dst_addr_o  = dst_r;
  assign len_o       = len_r;
  assign start_o     = start_r;
  assign busy_o      = run_s;

endmodule

// File: doc/aidc_lite_cfg.md
AIDC_LITE_CFG -- requirements
Module: aidc_lite_cfg

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: width of the APB address actually decoded.
REQ-002 SHALL have port clk  input  1: single clock for all logic.
REQ-003 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have ports psel, penable, pwrite  input  1 each: APB control.
REQ-005 SHALL have port paddr  input  ADDR_W: APB byte address.
REQ-006 SHALL have port pwdata  input  32: APB write data.
REQ-007 SHALL have port prdata  output  32: APB read data.
REQ-008 SHALL have ports pready and pslverr  output  1 each: APB ready and error.
REQ-009 SHALL have ports src_addr_o, dst_addr_o, len_o  output  32 each: job descriptor to the engine.
REQ-010 SHALL have port start_o  output  1: one-cycle job launch pulse to the engine.
REQ-011 SHALL have port done_i  input  1: one-cycle job-complete pulse from the engine.
REQ-012 SHALL have port busy_o  output  1: job in flight.
REQ-013 SHALL have port irq_o  output  1: completion interrupt; present only with AIDC_LITE_CFG_IRQ_EN.

Function
REQ-014 SHALL implement a register map: 0x00 SRC_ADDR (RW), 0x04 DST_ADDR (RW), 0x08 LEN (RW, bytes), 0x0C CMD (WO, bit0=start), 0x10 STATUS (RO: bit0 done, bit1 busy), 0x14 CYCLES (RO).
REQ-015 SHALL drive pready=1 at all times (zero wait states).
REQ-016 SHALL commit a write in the access cycle (psel & penable & pwrite) and update the register on the following clk edge.
REQ-017 SHALL register prdata in the setup cycle (psel & ~penable & ~pwrite) so it is valid throughout the access cycle.
REQ-018 SHALL force LEN[1:0] to 0 on write, so LEN is always word-aligned.
REQ-019 SHALL use a two-state FSM: IDLE -> RUN on an accepted start; RUN -> IDLE on done_i.
REQ-020 SHALL accept a start only when a CMD write with pwdata[0]=1 occurs in IDLE and LEN != 0; on acceptance it SHALL pulse start_o for exactly one cycle on the next edge, set busy, clear done, and clear CYCLES.
REQ-021 SHALL treat a CMD start with LEN=0 in IDLE as a null job: no start_o, state stays IDLE, and done=1 on the next edge.
REQ-022 SHALL ignore, and assert pslverr for the access cycle, any write to 0x00-0x0C while in RUN.
REQ-023 SHALL, when done_i coincides with a CMD write, treat the FSM as RUN for that write: the write is rejected with pslverr=1, and done_i is processed normally.
REQ-024 SHALL increment CYCLES by 1 every cycle in RUN, saturating at 0xFFFF_FFFF.
REQ-025 SHALL ignore done_i in IDLE.
REQ-026 SHALL return 0 for reads of unmapped addresses with pslverr=0, and SHALL discard writes to unmapped addresses.
REQ-027 SHALL read STATUS as exactly 0x1 after completion and before the next start.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously clear all registers, FSM (to IDLE), prdata, start_o, busy_o, pslverr and irq_o to 0.
REQ-029 SHALL on reset mid-job drop busy_o immediately, and SHALL NOT set done from a later stray done_i.

Configuration
REQ-030 SHALL, with AIDC_LITE_CFG_IRQ_EN defined, add an INTR register at 0x18 (bit0 enable RW, bit1 pending W1C) and drive irq_o = enable & pending.
REQ-031 SHALL set pending on the same edge that sets done; a W1C write coinciding with a set event SHALL leave pending=1.
REQ-032 SHALL, without AIDC_LITE_CFG_IRQ_EN, omit irq_o, treat 0x18 as unmapped, and keep all other behaviour identical.

Verification
REQ-033 SHALL cover: write SRC=0x1_0000, DST=0x2_0000, LEN=0x1000, CMD=1 -> start_o high for 1 cycle; STATUS=0x2; after done_i, STATUS=0x1.
REQ-034 SHALL cover: done_i 50 cycles after start_o -> CYCLES reads 50 (±1 per the defined edge alignment).
REQ-035 SHALL cover: write LEN=0x0 while in RUN -> pslverr=1 and LEN unchanged.
REQ-036 SHALL cover: LEN=0 then CMD=1 -> no start_o, STATUS=0x1 next cycle.
REQ-037 SHALL cover: LEN write of 0x803 -> reads back 0x800.
REQ-038 SHALL cover: IRQ build, INTR=1, job completes -> irq_o=1; write INTR=0x2 -> irq_o=0; rst_n low mid-job -> busy_o=0 asynchronously.
